regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised register file with an integrated per-register pending-write scoreboard, replacing the fixed 2-read/1-write register file in the decode stage.
- Supplies NRP read ports with same-cycle writeback bypass and tracks in-flight writes per destination register.
- Raises a decode stall when a source operand or destination counter is not ready, so hazard logic no longer recomputes register dependencies.
- Sits in ID; writeback and squash inputs arrive from WB and the flush logic.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of 2, ≥2); register 0 is hard-wired to zero
NRP, 2, number of read ports (1..4)
CNT_W, 2, width of per-register pending counter; max in-flight writes per register = 2^CNT_W-1
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
rs_addr  in  NRP*AW  read addresses, port i at [i*AW +: AW]
rs_used  in  NRP  port i operand is actually consumed by the instruction in ID
rdata  out  NRP*XLEN  read data, port i at [i*XLEN +: XLEN]
rbusy  out  NRP  port i source has an unresolved pending write
issue_valid  in  1  instruction in ID advances to EX this cycle (already qualified by stall_out from hazard unit)
issue_rd  in  AW  destination of issuing instruction
issue_we  in  1  issuing instruction writes issue_rd
wb_en  in  1  writeback write enable
wb_rd  in  AW  writeback address
wb_data  in  XLEN  writeback data
kill_en  in  1  a squashed in-flight instruction with a destination is retired without writing
kill_rd  in  AW  destination of squashed instruction
stall_out  out  1  ID must hold: operand hazard or pending-counter saturation

Behaviour:
- Reset (rst high at edge): all NREG data registers ← 0; all pending counters ← 0. Overrides issue/wb/kill in the same cycle. Mid-operation reset discards all in-flight tracking.
- After reset, with no activity: rdata = 0 and rbusy = 0 on every port; stall_out = 0.
- Write: on edge with wb_en && wb_rd≠0, reg[wb_rd] ← wb_data. Writes to register 0 are ignored; reg[0] always reads 0.
- Read (combinational, zero latency): rdata[i] = 0 if rs_addr[i]==0; else wb_data if wb_en && wb_rd==rs_addr[i]; else reg[rs_addr[i]].
- Pending counter pend[r] for r≠0; pend[0] is constant 0.
  - inc = issue_valid && issue_we && issue_rd==r && r≠0.
  - dec = (wb_en && wb_rd==r) + (kill_en && kill_rd==r), each contributing 1.
  - pend[r] ← pend[r] + inc − dec, evaluated for all r in parallel. Simultaneous inc and dec on the same r nets correctly.
  - A decrement at 0 is an error: the counter saturates at 0 and never wraps. Simulation asserts on it.
  - wb_en and kill_en naming the same register in one cycle is legal (dec = 2).
- rbusy[i] = pend[rs_addr[i]] − (wb_en && wb_rd==rs_addr[i]) > 0.
  - When the only pending write retires this cycle, the bypassed value is valid and rbusy = 0.
  - Kill never clears rbusy combinationally.
- sat = issue_we && issue_rd≠0 && pend[issue_rd] == 2^CNT_W−1 && !(wb_en && wb_rd==issue_rd).
- stall_out = OR_i(rs_used[i] && rbusy[i]) || sat. Purely combinational from inputs and state.
- If issue_valid is asserted while stall_out=1, the issue is ignored (no counter increment). The protocol forbids it, and simulation asserts on it.

Test Plan:
- Reset, then read all NRP ports at addresses 0, 5 -> rdata=0, rbusy=0, stall_out=0.
- Issue we to x5, then rs_addr[0]=5 with rs_used=1 -> rbusy[0]=1, stall_out=1 until wb. In the wb cycle (wb_rd=5, wb_data=0xDEADBEEF) -> rdata[0]=0xDEADBEEF, rbusy=0, stall_out=0. Next cycle, reg read returns 0xDEADBEEF.
- Issue x7 three times (CNT_W=2) -> pend=3; the fourth issue attempt shows stall_out=1. Same cycle with wb_rd=7 -> stall_out=0, pend stays 3.
- Issue x9, then kill_en with kill_rd=9 -> pend 0, rbusy clears next cycle. Register contents are unchanged.
- wb_en to x0 with data 0xFFFFFFFF, and issue_rd=0 -> reads of x0 stay 0, no busy, no stall. Additionally, rs_used=0 with a busy source -> stall_out=0.
- Assert rst with pend[3]=2 and reg[3]=0x1234 -> next cycle pend=0, reg[3]=0, rbusy=0. A wb issued in the reset cycle is ignored.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register pending-write counters.
// Reads bypass same-cycle writeback; stall_out covers operand hazards and counter saturation.

module regfile_scoreboard_rport #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int AW    = $clog2(NREG)
) (
  input  logic [AW-1:0]                 addr,
  input  logic                          used,
  input  logic [NREG-1:0][XLEN-1:0]     rf,
  input  logic [NREG-1:0][CNT_W-1:0]    pend,
  input  logic                          wb_en,
  input  logic [AW-1:0]                 wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  output logic [XLEN-1:0]               rdata,
  output logic                          rbusy,
  output logic                          hazard
);
  logic wb_hit;

  assign wb_hit = wb_en && (wb_rd == addr);

  always_comb begin
    rdata = rf[addr];
    if (addr == '0)  rdata = '0;
    else if (wb_hit) rdata = wb_data;
  end

  // A retiring write already satisfies one pending count; kill never does.
  assign rbusy  = pend[addr] > CNT_W'(wb_hit);
  assign hazard = used && rbusy;
endmodule

module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NRP   = 2,
  parameter int CNT_W = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP*AW-1:0]     rs_addr,
  input  logic [NRP-1:0]        rs_used,
  output logic [NRP*XLEN-1:0]   rdata,
  output logic [NRP-1:0]        rbusy,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  issue_we,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  kill_en,
  input  logic [AW-1:0]         kill_rd,
  output logic                  stall_out
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][XLEN-1:0]  rf;
  logic [NREG-1:0][CNT_W-1:0] pend, pend_nxt;
  logic [NREG-1:0]            uflow;
  logic [NRP-1:0]             hazard;
  logic                       sat, issue_ok;
  logic [CNT_W+1:0]           up, dec;

  for (genvar i = 0; i < NRP; i++) begin : g_rport
    regfile_scoreboard_rport #(
      .XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W), .AW(AW)
    ) u_rport (
      .addr    (rs_addr[i*AW +: AW]),
      .used    (rs_used[i]),
      .rf      (rf),
      .pend    (pend),
      .wb_en   (wb_en),
      .wb_rd   (wb_rd),
      .wb_data (wb_data),
      .rdata   (rdata[i*XLEN +: XLEN]),
      .rbusy   (rbusy[i]),
      .hazard  (hazard[i])
    );
  end

  assign sat = issue_we && (issue_rd != '0) && (pend[issue_rd] == CNT_MAX)
               && !(wb_en && (wb_rd == issue_rd));
  assign stall_out = (|hazard) || sat;
  assign issue_ok  = issue_valid && issue_we && !stall_out;

  always_comb begin
    pend_nxt = '0;
    uflow    = '0;
    up       = '0;
    dec      = '0;
    for (int r = 1; r < NREG; r++) begin
      up  = (CNT_W+2)'(pend[r]) + (CNT_W+2)'(issue_ok && (issue_rd == AW'(r)));
      dec = (CNT_W+2)'(wb_en && (wb_rd == AW'(r))) + (CNT_W+2)'(kill_en && (kill_rd == AW'(r)));
      // Underflow is a protocol error; hold at zero rather than wrap.
      uflow[r]    = up < dec;
      pend_nxt[r] = uflow[r] ? '0 : CNT_W'(up - dec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf   <= '0;
      pend <= '0;
    end else begin
      pend <= pend_nxt;
      if (wb_en && (wb_rd != '0)) rf[wb_rd] <= wb_data;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (uflow == '0);
      assert (!(issue_valid && stall_out));
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Random + directed bench for regfile_scoreboard against an array/counter reference model.

module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NRP   = 2;
  localparam int CNT_W = 2;
  localparam int AW    = $clog2(NREG);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRP*AW-1:0]    rs_addr;
  logic [NRP-1:0]       rs_used;
  logic [NRP*XLEN-1:0]  rdata;
  logic [NRP-1:0]       rbusy;
  logic                 issue_valid, issue_we, wb_en, kill_en, stall_out;
  logic [AW-1:0]        issue_rd, wb_rd, kill_rd;
  logic [XLEN-1:0]      wb_data;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_used(rs_used), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .kill_en(kill_en), .kill_rd(kill_rd),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] mreg [NREG];
  int              mpend [NREG];
  bit              mknown = 0;
  int              n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] m_rd(int a);
    if (a == 0) return '0;
    if (wb_en && int'(wb_rd) == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic bit m_busy(int a);
    return (mpend[a] - ((wb_en && int'(wb_rd) == a) ? 1 : 0)) > 0;
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    for (int p = 0; p < NRP; p++)
      if (rs_used[p] && m_busy(int'(rs_addr[p*AW +: AW]))) s = 1;
    if (issue_we && issue_rd != 0 && mpend[issue_rd] == CMAX && !(wb_en && wb_rd == issue_rd)) s = 1;
    return s;
  endfunction

  task automatic check_outputs();
    if (!mknown) return;
    for (int p = 0; p < NRP; p++) begin
      int a = int'(rs_addr[p*AW +: AW]);
      chk($sformatf("rdata%0d", p), rdata[p*XLEN +: XLEN], m_rd(a));
      chk($sformatf("rbusy%0d", p), rbusy[p], m_busy(a));
    end
    chk("stall", stall_out, m_stall());
  endtask

  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin mreg[r] = '0; mpend[r] = 0; end
      mknown = 1;
    end else if (mknown) begin
      bit st = m_stall();
      if (issue_valid && issue_we && !st && issue_rd != 0) mpend[issue_rd]++;
      if (wb_en && wb_rd != 0) begin mreg[wb_rd] = wb_data; mpend[wb_rd]--; end
      if (kill_en && kill_rd != 0) mpend[kill_rd]--;
      for (int r = 0; r < NREG; r++) if (mpend[r] < 0) mpend[r] = 0;
    end
  endtask

  task automatic cyc();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; rs_addr = '0; rs_used = '0;
    issue_valid = 0; issue_we = 0; issue_rd = '0;
    wb_en = 0; wb_rd = '0; wb_data = '0; kill_en = 0; kill_rd = '0;
  endtask

  task automatic set_rs(input int p, input int a, input bit u);
    rs_addr[p*AW +: AW] = AW'(a);
    rs_used[p] = u;
  endtask

  task automatic issue(input int rd);
    idle(); issue_valid = 1; issue_we = 1; issue_rd = AW'(rd); cyc();
  endtask

  task automatic wb(input int rd, input logic [XLEN-1:0] d);
    idle(); wb_en = 1; wb_rd = AW'(rd); wb_data = d; cyc();
  endtask

  task automatic rand_step();
    int pl[$];
    idle();
    rst = ($urandom_range(199) == 0);
    for (int p = 0; p < NRP; p++) set_rs(p, $urandom_range(7), 1'($urandom_range(1)));
    for (int r = 1; r < NREG; r++) if (mpend[r] > 0) pl.push_back(r);
    if (pl.size() > 0 && $urandom_range(2) == 0) begin
      wb_en = 1; wb_rd = AW'(pl[$urandom_range(pl.size()-1)]); wb_data = XLEN'($urandom);
    end else if ($urandom_range(9) == 0) begin
      wb_en = 1; wb_rd = '0; wb_data = XLEN'($urandom);
    end
    if (pl.size() > 0 && $urandom_range(4) == 0) begin
      int r = pl[$urandom_range(pl.size()-1)];
      if (mpend[r] - ((wb_en && int'(wb_rd) == r) ? 1 : 0) >= 1) begin kill_en = 1; kill_rd = AW'(r); end
    end
    issue_we = ($urandom_range(3) != 0);
    issue_rd = AW'($urandom_range(7));
    if ($urandom_range(1) == 1) issue_valid = !m_stall();
    cyc();
  endtask

  initial begin
    idle(); rst = 1; cyc();

    // reset state
    idle(); set_rs(0, 0, 1); set_rs(1, 5, 1);
    #1 chk("rst_rd0", rdata[XLEN-1:0], 0); chk("rst_rd1", rdata[XLEN +: XLEN], 0);
    chk("rst_busy", rbusy, 0); chk("rst_stall", stall_out, 0);
    cyc();

    // RAW on x5, resolved by bypass
    issue(5);
    idle(); set_rs(0, 5, 1);
    #1 chk("x5_busy", rbusy[0], 1); chk("x5_stall", stall_out, 1);
    cyc(); cyc();
    wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    #1 chk("x5_byp", rdata[XLEN-1:0], 32'hDEADBEEF); chk("x5_byp_busy", rbusy[0], 0);
    chk("x5_byp_stall", stall_out, 0);
    cyc();
    idle(); set_rs(0, 5, 1);
    #1 chk("x5_reg", rdata[XLEN-1:0], 32'hDEADBEEF);
    cyc();

    // counter saturation on x7
    repeat (3) issue(7);
    idle(); issue_we = 1; issue_rd = 7;
    #1 chk("sat_stall", stall_out, 1);
    cyc();
    wb_en = 1; wb_rd = 7; wb_data = 32'h77;
    #1 chk("sat_wb_stall", stall_out, 0);
    issue_valid = 1;
    cyc();
    idle(); issue_we = 1; issue_rd = 7;
    #1 chk("sat_hold", stall_out, 1);
    cyc();
    repeat (3) wb(7, 32'h70);
    idle(); set_rs(0, 7, 1);
    #1 chk("x7_free", rbusy[0], 0);
    cyc();

    // kill on x9
    issue(9); wb(9, 32'h55); issue(9);
    idle(); kill_en = 1; kill_rd = 9; set_rs(0, 9, 1);
    #1 chk("kill_busy_same", rbusy[0], 1);
    cyc();
    idle(); set_rs(0, 9, 1);
    #1 chk("kill_clr", rbusy[0], 0); chk("kill_data", rdata[XLEN-1:0], 32'h55);
    cyc();

    // x0 writes and issues
    idle(); wb_en = 1; wb_rd = 0; wb_data = '1;
    issue_valid = 1; issue_we = 1; issue_rd = 0; set_rs(0, 0, 1); set_rs(1, 0, 1);
    #1 chk("x0_byp", rdata, 0); chk("x0_busy", rbusy, 0); chk("x0_stall", stall_out, 0);
    cyc();
    idle(); set_rs(0, 0, 1);
    #1 chk("x0_reg", rdata[XLEN-1:0], 0);
    cyc();
    issue(11);
    idle(); set_rs(0, 11, 0);
    #1 chk("unused_busy", rbusy[0], 1); chk("unused_stall", stall_out, 0);
    cyc();
    idle(); kill_en = 1; kill_rd = 11; cyc();

    // mid-operation reset
    issue(3); wb(3, 32'h1234); issue(3); issue(3);
    idle(); set_rs(0, 3, 1);
    #1 chk("pre_rst_busy", rbusy[0], 1); chk("pre_rst_data", rdata[XLEN-1:0], 32'h1234);
    cyc();
    idle(); rst = 1; wb_en = 1; wb_rd = 3; wb_data = 32'hBAD;
    cyc();
    idle(); set_rs(0, 3, 1); issue_we = 1; issue_rd = 3;
    #1 chk("rst_x3_data", rdata[XLEN-1:0], 0); chk("rst_x3_busy", rbusy[0], 0);
    chk("rst_x3_stall", stall_out, 0);
    cyc();

    repeat (3000) rand_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
